// File: rtl/fp16_pkg.sv
// -----------------------------------------------------------------------------
// fp16_pkg
// Shared float16 format constants and helpers for the multiply/accumulate lane.
// Format: 1 sign, 5 exponent, 10 fraction. There are no denormals and no
// Inf/NaN. Results saturate to the largest normal and flush to the smallest
// normal.
// No ports (package).
// -----------------------------------------------------------------------------
package fp16_pkg;

    localparam int DATA_W        = 16;
    localparam int EXP_W         = 5;
    localparam int FRAC_W        = 10;
    // Hidden one + fraction + three guard positions used during alignment.
    localparam int MANT_W        = FRAC_W + 4;

    localparam int FP16_EXP_BIAS = 15;
    localparam int FP16_MIN_EXP  = 1;
    localparam int FP16_MAX_EXP  = 30;
    localparam logic [DATA_W-1:0] FP16_MAX_POS = 16'h7BFF;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_FULL = 1'b1
    } stage_state_t;

    // Both +0 (0x0000) and -0 (0x8000) count as zero.
    function automatic logic fp16_is_zero(input logic [DATA_W-1:0] v);
        return (v[DATA_W-2:0] == '0);
    endfunction

endpackage

// File: rtl/fp16_add_comb.sv
// -----------------------------------------------------------------------------
// fp16_add_comb
// Purely combinational float16 adder. It uses the multiplier's number format.
// Alignment truncates the bits shifted out (there is no sticky bit).
// Rounding is round-half-up on the first bit dropped below the fraction.
// Ports:
//   i_a, i_b : float16 operands
//   o_sum    : float16 sum
// -----------------------------------------------------------------------------
module fp16_add_comb
    import fp16_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_sum
);

    localparam logic signed [7:0] E_MIN = 8'(FP16_MIN_EXP);
    localparam logic signed [7:0] E_MAX = 8'(FP16_MAX_EXP);

    // Count leading zeros of a non-zero aligned mantissa.
    function automatic logic [3:0] lzc14(input logic [MANT_W-1:0] v);
        logic [3:0] n;
        logic       found;
        n     = 4'd0;
        found = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 4'd1;
            end
        end
        return n;
    endfunction

    // Round the normalized mantissa (leading one at the MSB), then saturate or flush.
    function automatic logic [DATA_W-1:0] round_sat(
        input logic                    sign,
        input logic signed [7:0]       exp_in,
        input logic [MANT_W-1:0]       mant
    );
        logic [FRAC_W+1:0] r;
        logic signed [7:0] e;
        r = {1'b0, mant[MANT_W-1:3]} + {{(FRAC_W+1){1'b0}}, mant[2]};
        e = exp_in;
        // 1.111..1 + half LSB carries into 10.000..0, so renormalize.
        if (r[FRAC_W+1]) begin
            r = r >> 1;
            e = e + 8'sd1;
        end
        if (e < E_MIN)
            return {sign, 5'(FP16_MIN_EXP), {FRAC_W{1'b0}}};
        else if (e > E_MAX)
            return {sign, FP16_MAX_POS[DATA_W-2:0]};
        else
            return {sign, e[EXP_W-1:0], r[FRAC_W-1:0]};
    endfunction

    logic                    w_a_zero;
    logic                    w_b_zero;
    logic                    w_a_big;
    logic                    w_sign_l;
    logic [EXP_W-1:0]        w_exp_l;
    logic [EXP_W-1:0]        w_exp_s;
    logic [EXP_W-1:0]        w_diff;
    logic [MANT_W-1:0]       w_mant_l;
    logic [MANT_W-1:0]       w_mant_s;
    logic [MANT_W-1:0]       w_mant_s_sh;
    logic [MANT_W:0]         w_sum;
    logic [MANT_W-1:0]       w_norm;
    logic signed [7:0]       w_exp_n;
    logic [3:0]              w_lz;
    logic                    w_cancel;

    assign w_a_zero = fp16_is_zero(i_a);
    assign w_b_zero = fp16_is_zero(i_b);

    // The exponent sits above the fraction, so an unsigned compare of the
    // magnitude bits orders the operands by magnitude.
    assign w_a_big  = (i_a[DATA_W-2:0] >= i_b[DATA_W-2:0]);
    assign w_sign_l = w_a_big ? i_a[DATA_W-1] : i_b[DATA_W-1];
    assign w_exp_l  = w_a_big ? i_a[DATA_W-2:FRAC_W] : i_b[DATA_W-2:FRAC_W];
    assign w_exp_s  = w_a_big ? i_b[DATA_W-2:FRAC_W] : i_a[DATA_W-2:FRAC_W];
    assign w_mant_l = w_a_big ? {1'b1, i_a[FRAC_W-1:0], 3'b000} : {1'b1, i_b[FRAC_W-1:0], 3'b000};
    assign w_mant_s = w_a_big ? {1'b1, i_b[FRAC_W-1:0], 3'b000} : {1'b1, i_a[FRAC_W-1:0], 3'b000};
    assign w_diff   = w_exp_l - w_exp_s;

    assign w_mant_s_sh = (w_diff >= 5'(MANT_W)) ? '0 : (w_mant_s >> w_diff);

    always_comb begin
        w_sum    = '0;
        w_norm   = '0;
        w_lz     = '0;
        w_cancel = 1'b0;
        w_exp_n  = $signed({3'b000, w_exp_l});
        if (i_a[DATA_W-1] == i_b[DATA_W-1]) begin
            w_sum = {1'b0, w_mant_l} + {1'b0, w_mant_s_sh};
            if (w_sum[MANT_W]) begin
                w_norm  = w_sum[MANT_W:1];
                w_exp_n = w_exp_n + 8'sd1;
            end else begin
                w_norm  = w_sum[MANT_W-1:0];
            end
        end else begin
            w_sum = {1'b0, w_mant_l - w_mant_s_sh};
            if (w_sum[MANT_W-1:0] == '0) begin
                w_cancel = 1'b1;
            end else begin
                w_lz    = lzc14(w_sum[MANT_W-1:0]);
                w_norm  = w_sum[MANT_W-1:0] << w_lz;
                w_exp_n = w_exp_n - $signed({4'b0000, w_lz});
            end
        end
    end

    // A zero operand passes the other operand through unchanged, including -0.
    always_comb begin
        if (w_a_zero)
            o_sum = i_b;
        else if (w_b_zero)
            o_sum = i_a;
        else if (w_cancel)
            o_sum = '0;
        else
            o_sum = round_sat(w_sign_l, w_exp_n, w_norm);
    end

endmodule

// File: rtl/fp16_accum_stage.sv
// -----------------------------------------------------------------------------
// fp16_accum_stage
// Accumulate half of a dot-product lane. The stage sums each group of float16
// products, ended by in_last, into one float16 result. It accepts one beat per
// cycle. A group's sum is registered on the edge that accepts its last beat.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : product beat handshake
//   in_data, in_last      : float16 product, end-of-group marker
//   out_valid/out_ready   : group sum handshake
//   out_data, out_count   : float16 group sum, saturating beat count
// -----------------------------------------------------------------------------
module fp16_accum_stage
    import fp16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [CNT_W-1:0]  out_count
);

    stage_state_t       r_state;
    logic [15:0]        r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_out_data;
    logic [CNT_W-1:0]   r_out_count;

    logic               w_accept;
    logic               w_xfer;
    logic               w_close;
    logic [15:0]        w_sum;
    logic [CNT_W-1:0]   w_cnt_inc;

    fp16_add_comb u_add (
        .i_a   (r_acc),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

    // The held sum may be replaced on the same edge that it is transferred.
    // This keeps back-to-back groups free of bubbles.
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;
    assign w_close   = w_accept && in_last;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    // Stage boundary: running sum and finished-group result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            if (w_accept) begin
                if (in_last) begin
                    r_out_data  <= w_sum;
                    r_out_count <= w_cnt_inc;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc       <= w_sum;
                    r_cnt       <= w_cnt_inc;
                end
            end
            case (r_state)
                ST_ACC:  if (w_close) r_state <= ST_FULL;
                ST_FULL: if (w_xfer && !w_close) r_state <= ST_ACC;
                default: r_state <= ST_ACC;
            endcase
        end
    end

endmodule
